// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Byte, half-word and word enables that a lane-positioned access may carry.
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    function automatic logic mask_legal(logic [3:0] m);
        case (m)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3,
            MASK_H0, MASK_H1, MASK_W: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: DEPTH_WORDS x 32, byte-enabled write.
// Latency: write takes effect on the next rising edge; read is combinational.
// Backpressure: none; always ready.
// Ports: clk; i_we write strobe; i_idx word index (shared by read and write);
//        i_be per-byte write enables; i_wdata write data; o_rdata word at i_idx.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [3:0]       i_be,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    // Contents are deliberately not reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store port: one byte-masked store or full-word load at a time.
// Latency: rsp_valid appears LATENCY cycles after the request handshake cycle (LATENCY 1..15).
// Backpressure: one transaction in flight; req_ready stays low from accept until the response is taken.
// Ports: clk, rst (async, active high); req_valid/req_ready handshake with req_addr (byte address,
//        [1:0] ignored), req_we, req_mask (lane-positioned byte enables), req_wdata;
//        rsp_valid/rsp_ready handshake with rsp_rdata (loads only, else 0) and rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [3:0]        req_mask,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int                IDX_W    = $clog2(DEPTH_WORDS);
    localparam int                WIDX_W   = ADDR_W - 2;
    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [WIDX_W-1:0] DEPTH_L  = WIDX_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end

    dmem_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [WIDX_W-1:0] r_widx;
    logic              r_we;
    logic [3:0]        r_mask;
    logic [31:0]       r_wdata;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0]       r_rsp_rdata, w_rsp_rdata_nxt;
    logic              r_rsp_err,   w_rsp_err_nxt;

    logic              w_accept;
    logic              w_commit;
    logic [WIDX_W-1:0] w_c_widx;
    logic              w_c_we;
    logic [3:0]        w_c_mask;
    logic [31:0]       w_c_wdata;
    logic              w_c_err;
    logic              w_mem_we;
    logic [31:0]       w_mem_rdata;
    logic              w_addr_unused;

    // Byte offset carries no information: the mask is already lane-positioned.
    assign w_addr_unused = ^req_addr[1:0];

    assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;

    // With LATENCY==1 the commit happens on the accept edge itself, before the
    // request latch holds anything, so the commit reads the live request then.
    assign w_c_widx  = w_accept ? req_addr[ADDR_W-1:2] : r_widx;
    assign w_c_we    = w_accept ? req_we               : r_we;
    assign w_c_mask  = w_accept ? req_mask             : r_mask;
    assign w_c_wdata = w_accept ? req_wdata            : r_wdata;

    // A load with an empty mask is a plain full-word read.
    assign w_c_err = (w_c_widx >= DEPTH_L) ||
                     !(mask_legal(w_c_mask) || (!w_c_we && (w_c_mask == 4'b0000)));

    assign w_mem_we = w_commit && w_c_we && !w_c_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_idx   (w_c_widx[IDX_W-1:0]),
        .i_be    (w_c_mask),
        .i_wdata (w_c_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        w_commit        = 1'b0;

        case (r_state)
            IDLE: begin
                // Also raises req_ready on the first edge after reset releases.
                w_req_ready_nxt = 1'b1;
                if (w_accept) begin
                    w_req_ready_nxt = 1'b0;
                    w_cnt_nxt       = CNT_INIT;
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_err_nxt   = 1'b0;
                    w_req_ready_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Entry into RESP is the commit point: the store lands and the load samples.
        if (w_commit) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = w_c_err;
            w_rsp_rdata_nxt = (w_c_err || w_c_we) ? 32'd0 : w_mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_widx      <= '0;
            r_we        <= 1'b0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_accept) begin
                r_widx  <= req_addr[ADDR_W-1:2];
                r_we    <= req_we;
                r_mask  <= req_mask;
                r_wdata <= req_wdata;
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and LATENCY 1) sharing clock and reset.
// Driver pushes expected responses from a word-array reference model; per-DUT monitors pop and compare.
// Backpressure on the response side is always-ready, random, or held low depending on rdy_mode.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid_s [2];
    logic        req_ready_s [2];
    logic [31:0] req_addr_s  [2];
    logic        req_we_s    [2];
    logic [3:0]  req_mask_s  [2];
    logic [31:0] req_wdata_s [2];
    logic        rsp_valid_s [2];
    logic        rsp_ready_s [2];
    logic [31:0] rsp_rdata_s [2];
    logic        rsp_err_s   [2];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
    exp_t sbq [$];
    logic [31:0] mdl_mem [2][DEPTH];

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_addr(req_addr_s[0]),
        .req_we(req_we_s[0]), .req_mask(req_mask_s[0]), .req_wdata(req_wdata_s[0]),
        .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
        .rsp_rdata(rsp_rdata_s[0]), .rsp_err(rsp_err_s[0])
    );

    dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_addr(req_addr_s[1]),
        .req_we(req_we_s[1]), .req_mask(req_mask_s[1]), .req_wdata(req_wdata_s[1]),
        .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
        .rsp_rdata(rsp_rdata_s[1]), .rsp_err(rsp_err_s[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, event not seen (cycle %0d)", name, cyc);
    endtask

    // Reference model: the memory is an array of words; a store replaces exactly
    // the enabled bytes, a load returns the whole word.
    task automatic model(input int d, input bit we, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata,
                         input bit apply, output exp_t e);
        int unsigned idx;
        bit          legal;
        logic [31:0] bytes_on;
        idx   = int'(addr[31:2]);
        legal = (mask inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) ||
                (!we && mask == 4'b0000);
        e.err   = (idx >= DEPTH) || !legal;
        e.rdata = 32'd0;
        if (!e.err) begin
            if (we) begin
                bytes_on = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
                if (apply) mdl_mem[d][idx] = (mdl_mem[d][idx] & ~bytes_on) | (wdata & bytes_on);
            end else begin
                e.rdata = mdl_mem[d][idx];
            end
        end
    endtask

    // Presents a request, waits (bounded) for the handshake, records the expected response.
    task automatic do_req(input int d, input bit we, input logic [31:0] addr, input logic [3:0] mask,
                          input logic [31:0] wdata, input bit apply, output int acc);
        exp_t e;
        int   waited;
        waited         = 0;
        req_valid_s[d] = 1'b1;
        req_we_s[d]    = we;
        req_addr_s[d]  = addr;
        req_mask_s[d]  = mask;
        req_wdata_s[d] = wdata;
        while (!req_ready_s[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_s[d]) begin
            timeout_fail("req_accept");
            req_valid_s[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        model(d, we, addr, mask, wdata, apply, e);
        e.dut = d;
        e.acc = acc;
        e.lat = (d == 0) ? LAT0 : LAT1;
        sbq.push_back(e);
        @(negedge clk);
        req_valid_s[d] = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready_s[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_s[0], 32'd0);
        check("rst_rsp_err",   32'(rsp_err_s[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_req_ready", 32'(req_ready_s[0]), 32'd1);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0) timeout_fail("drain");
    endtask

    // Response-side backpressure
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                case (rdy_mode)
                    0:       rsp_ready_s[d] = 1'b1;
                    1:       rsp_ready_s[d] = 1'($urandom_range(0, 1));
                    default: rsp_ready_s[d] = 1'b0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mon
        bit seen = 1'b0;
        always @(negedge clk) begin
            #1;
            if (rst) begin
                seen = 1'b0;
                sbq.delete();
            end else if (rsp_valid_s[g]) begin
                if (sbq.size() == 0 || sbq[0].dut != g) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected 0 (cycle %0d)", g, cyc);
                end else begin
                    if (!seen) begin
                        check("rsp_latency", 32'(cyc), 32'(sbq[0].acc + sbq[0].lat - 1));
                        seen = 1'b1;
                    end
                    check("rsp_rdata", rsp_rdata_s[g], sbq[0].rdata);
                    check("rsp_err", 32'(rsp_err_s[g]), 32'(sbq[0].err));
                    if (rsp_ready_s[g]) begin
                        void'(sbq.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int          acc, prev, w;
        logic [31:0] a;
        logic [3:0]  m;
        logic [3:0]  legal_masks [7];
        legal_masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int d = 0; d < 2; d++) begin
            req_valid_s[d] = 1'b0;
            req_we_s[d]    = 1'b0;
            req_addr_s[d]  = 32'd0;
            req_mask_s[d]  = 4'd0;
            req_wdata_s[d] = 32'd0;
            for (int i = 0; i < DEPTH; i++) mdl_mem[d][i] = 32'd0;
        end
        rdy_mode = 0;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_req_ready", 32'(req_ready_s[d]), 32'd0);
            check("reset_rsp_valid", 32'(rsp_valid_s[d]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata_s[d], 32'd0);
            check("reset_rsp_err",   32'(rsp_err_s[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 32'(req_ready_s[0]), 32'd0);
        @(negedge clk);
        #1;
        check("ready_after_first_edge", 32'(req_ready_s[0]), 32'd1);
        check("ready_after_first_edge_l1", 32'(req_ready_s[1]), 32'd1);

        // Word store then readback; single-byte merge; errors
        do_req(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b1, acc);
        do_req(0, 1'b0, 32'h10, 4'b0000, 32'h0, 1'b1, acc);
        do_req(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 1'b1, acc);
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b1, acc);
        do_req(0, 1'b0, 32'h1000, 4'b1111, 32'h0, 1'b1, acc);
        do_req(0, 1'b1, 32'h10, 4'b0110, 32'hFFFFFFFF, 1'b1, acc);
        do_req(0, 1'b1, 32'h10, 4'b0000, 32'h11111111, 1'b1, acc);
        do_req(0, 1'b0, 32'h10, 4'b0110, 32'h0, 1'b1, acc);
        do_req(0, 1'b0, 32'h13, 4'b0000, 32'h0, 1'b1, acc);
        do_req(0, 1'b1, 32'hFFC, 4'b1100, 32'h77660000, 1'b1, acc);
        do_req(0, 1'b0, 32'hFFC, 4'b0000, 32'h0, 1'b1, acc);
        drain();

        // Response held for 5 cycles; a competing request must be ignored
        rdy_mode = 2;
        do_req(0, 1'b0, 32'h10, 4'b1111, 32'h0, 1'b1, acc);
        w = 0;
        while (!rsp_valid_s[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!rsp_valid_s[0]) timeout_fail("hold_rsp_valid_rise");
        for (int i = 0; i < 5; i++) begin
            req_valid_s[0] = 1'b1;
            req_we_s[0]    = 1'b1;
            req_addr_s[0]  = 32'h14;
            req_mask_s[0]  = 4'b1111;
            req_wdata_s[0] = 32'hCAFEF00D;
            @(negedge clk);
            #2;
            check("hold_rsp_valid", 32'(rsp_valid_s[0]), 32'd1);
            check("hold_req_ready", 32'(req_ready_s[0]), 32'd0);
        end
        req_valid_s[0] = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        #2;
        check("release_rsp_valid_before_edge", 32'(rsp_valid_s[0]), 32'd1);
        @(negedge clk);
        #2;
        check("release_req_ready", 32'(req_ready_s[0]), 32'd1);
        check("release_rsp_valid", 32'(rsp_valid_s[0]), 32'd0);
        do_req(0, 1'b0, 32'h14, 4'b1111, 32'h0, 1'b1, acc);
        drain();

        // Reset while the store is still waiting: never written
        do_req(0, 1'b1, 32'h20, 4'b1111, 32'h12345678, 1'b0, acc);
        #2;
        check("wait_rsp_valid_low", 32'(rsp_valid_s[0]), 32'd0);
        reset_pulse();
        do_req(0, 1'b0, 32'h20, 4'b1111, 32'h0, 1'b1, acc);
        drain();

        // Reset while the committed store sits in RESP: stays written
        rdy_mode = 2;
        do_req(0, 1'b1, 32'h24, 4'b1111, 32'hA5A55A5A, 1'b1, acc);
        @(negedge clk);
        #2;
        check("resp_rsp_valid_high", 32'(rsp_valid_s[0]), 32'd1);
        reset_pulse();
        rdy_mode = 0;
        do_req(0, 1'b0, 32'h24, 4'b1111, 32'h0, 1'b1, acc);
        drain();

        // Randomised traffic with random response backpressure
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       a = (32'(1024 + $urandom_range(0, 500)) << 2) | 32'($urandom_range(0, 3));
                1:       a = (32'd1023 << 2) | 32'($urandom_range(0, 3));
                default: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 1) == 0) m = legal_masks[$urandom_range(0, 6)];
            else                           m = 4'($urandom_range(0, 15));
            do_req(0, 1'($urandom_range(0, 1)), a, m, $urandom, 1'b1, acc);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // LATENCY=1: back-to-back traffic, one accept every 2 cycles
        for (int i = 0; i < 4; i++) do_req(1, 1'b1, 32'(i * 4), 4'b1111, $urandom, 1'b1, acc);
        prev = acc;
        for (int i = 0; i < 20; i++) begin
            do_req(1, 1'b0, 32'($urandom_range(0, 7) * 4), 4'b1111, 32'h0, 1'b1, acc);
            check("b2b_accept_spacing", 32'(acc - prev), 32'd2);
            prev = acc;
        end
        do_req(1, 1'b1, 32'h8, 4'b0010, 32'h0000BB00, 1'b1, acc);
        do_req(1, 1'b0, 32'h8, 4'b0000, 32'h0, 1'b1, acc);
        do_req(1, 1'b0, 32'h2000, 4'b1111, 32'h0, 1'b1, acc);
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
